// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// Single-clock FIFO controller in front of a dual-port RAM with registered
// read data. Port A of the RAM takes the writes and port B the reads. A
// 2-entry output buffer (obuf) absorbs the 1-cycle read latency, so both
// sides can move one word per cycle.
//
// Ports
//   clk, rst_n           clock and synchronous active-low reset
//   s_valid/s_ready/s_data   upstream stream
//   m_valid/m_ready/m_data   downstream stream (valid and data come from flops)
//   count                total words held (RAM + in-flight read + obuf)
//   ram_wr/ram_waddr/ram_wdata   RAM port A write side
//   ram_raddr/ram_rdata  RAM port B read side (data valid 1 cycle after address)
module ram_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int WORDS = 256,
  localparam int AW   = $clog2(WORDS),
  localparam int CW   = $clog2(WORDS + 3)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] count,
  output logic          ram_wr,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(WORDS);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   ram_cnt_q;
  logic          inflight_q;
  logic [DW-1:0] obuf_q [2];
  logic          obuf_hd_q, obuf_tl_q;
  logic [1:0]    obuf_cnt_q;
  logic [CW-1:0] count_q;

  logic          push, pop, issue;
  logic [1:0]    obuf_cnt_d;
  logic [AW:0]   ram_cnt_d;
  logic [CW-1:0] count_d;

  // s_ready looks only at the RAM occupancy, never at m_ready.
  assign s_ready = rst_n && (ram_cnt_q != RAM_FULL);
  assign push    = s_valid && s_ready;
  assign m_valid = (obuf_cnt_q != 2'd0);
  assign m_data  = obuf_q[obuf_hd_q];
  assign pop     = m_valid && m_ready;

  // Next obuf occupancy: the in-flight word always lands at this edge.
  // A new read may only be issued if it will still have a free slot
  // when its data returns next cycle.
  assign obuf_cnt_d = obuf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue      = (ram_cnt_q != '0) && (obuf_cnt_d < 2'd2);

  assign ram_cnt_d = ram_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
  assign count_d   = count_q + CW'(push) - CW'(pop);

  assign ram_wr    = push;
  assign ram_waddr = wptr_q;
  assign ram_wdata = s_data;
  assign ram_raddr = rptr_q;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      obuf_q[0]  <= '0;
      obuf_q[1]  <= '0;
      obuf_hd_q  <= 1'b0;
      obuf_tl_q  <= 1'b0;
      obuf_cnt_q <= 2'd0;
      count_q    <= '0;
    end else begin
      if (push)  wptr_q <= wptr_q + 1'b1;
      if (issue) rptr_q <= rptr_q + 1'b1;
      // Clearing inflight on reset drops a pending read; its data is ignored.
      inflight_q <= issue;
      if (inflight_q) begin
        obuf_q[obuf_tl_q] <= ram_rdata;
        obuf_tl_q         <= ~obuf_tl_q;
      end
      if (pop) obuf_hd_q <= ~obuf_hd_q;
      obuf_cnt_q <= obuf_cnt_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with WORDS=4 and a behavioural RAM model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int WORDS = 4;
  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS + 3);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          ram_wr;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DW(DW), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .ram_wr(ram_wr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // Dual-port RAM, registered read.
  logic [DW-1:0] mem [WORDS];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic sv, input logic [DW-1:0] d, input logic mr);
    s_valid = sv; s_data = d; m_ready = mr;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_m_data", m_data, 0);
    rst_n = 1'b1;
    next_cycle();
  endtask

  typedef struct {
    logic sv; logic [DW-1:0] d; logic mr;
    logic e_sr; logic e_mv; logic [DW-1:0] e_md; int e_cnt;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(logic sv, logic [DW-1:0] d, logic mr,
                              logic e_sr, logic e_mv, logic [DW-1:0] e_md, int e_cnt);
    vec_t v;
    v.sv = sv; v.d = d; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Reference model: FIFO of words with the cycle each was pushed in.
  logic [DW-1:0] q [$];
  int            qt [$];

  initial begin
    int got;
    int npush;
    logic [DW-1:0] exp_d;
    logic sv, mr;
    logic [DW-1:0] d;
    logic exp_mv;

    // single word A5, then fill to capacity and drain
    tbl.push_back(mk(1, 8'hA5, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'hA5, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 8'h00, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 8'h01, 0, 1, 0, 8'h00, 1));
    tbl.push_back(mk(1, 8'h02, 0, 1, 0, 8'h00, 2));
    tbl.push_back(mk(1, 8'h03, 0, 1, 1, 8'h00, 3));
    tbl.push_back(mk(1, 8'h04, 0, 1, 1, 8'h00, 4));
    tbl.push_back(mk(1, 8'h05, 0, 1, 1, 8'h00, 5));
    tbl.push_back(mk(1, 8'hEE, 0, 0, 1, 8'h00, 6));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h00, 6));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h01, 5));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h02, 4));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h03, 3));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h04, 2));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h05, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].sv, tbl[i].d, tbl[i].mr);
      @(negedge clk);
      chk($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_sr);
      chk($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].e_md);
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
      next_cycle();
    end

    // continuous push of 3*WORDS words with m_ready high
    do_reset();
    for (int k = 0; k < 3 * WORDS + 6; k++) begin
      set_in(k < 3 * WORDS, DW'(k), 1'b1);
      @(negedge clk);
      exp_mv = (k >= 3) && (k < 3 * WORDS + 3);
      chk($sformatf("cont%0d_m_valid", k), m_valid, exp_mv);
      if (exp_mv) chk($sformatf("cont%0d_m_data", k), m_data, k - 3);
      chk($sformatf("cont%0d_count_le3", k), count <= 3, 1);
      next_cycle();
    end

    // full FIFO: push attempted together with a pop is rejected, then accepted
    do_reset();
    for (int k = 0; k < WORDS + 2; k++) begin
      set_in(1'b1, DW'(8'h10 + k), 1'b0);
      next_cycle();
    end
    set_in(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("full_count", count, WORDS + 2);
    chk("full_s_ready", s_ready, 0);
    next_cycle();
    set_in(1'b1, 8'h77, 1'b1);
    @(negedge clk);
    chk("fullpop_s_ready", s_ready, 0);
    chk("fullpop_m_data", m_data, 8'h10);
    next_cycle();
    set_in(1'b1, 8'h77, 1'b0);
    @(negedge clk);
    chk("afterpop_count", count, WORDS + 1);
    chk("afterpop_s_ready", s_ready, 1);
    next_cycle();
    set_in(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("refill_count", count, WORDS + 2);
    chk("refill_s_ready", s_ready, 0);
    next_cycle();
    got = 0;
    for (int k = 0; k < 20 && got < WORDS + 2; k++) begin
      set_in(1'b0, '0, 1'b1);
      @(negedge clk);
      if (m_valid) begin
        exp_d = (got < WORDS + 1) ? DW'(8'h11 + got) : 8'h77;
        chk($sformatf("fulldrain%0d_data", got), m_data, exp_d);
        got++;
      end
      next_cycle();
    end
    chk("fulldrain_words", got, WORDS + 2);

    // reset with 3 words held and a read in flight
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, DW'(8'h50 + k), 1'b0);
      next_cycle();
    end
    set_in(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("midrst_count_before", count, 3);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    set_in(1'b1, 8'h3C, 1'b1);
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_s_ready", s_ready, 1);
    next_cycle();
    got = 0;
    for (int k = 0; k < 8 && got == 0; k++) begin
      set_in(1'b0, '0, 1'b1);
      @(negedge clk);
      if (m_valid) begin
        chk("midrst_first_out", m_data, 8'h3C);
        got = 1;
      end
      next_cycle();
    end
    if (got == 0) chk("midrst_timeout", 0, 1);

    // random traffic against the reference queue
    do_reset();
    q.delete(); qt.delete();
    npush = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      sv = 1'($urandom);
      mr = 1'($urandom);
      d  = DW'($urandom);
      set_in(sv, d, mr);
      @(negedge clk);
      chk("rnd_count", count, q.size());
      exp_mv = (q.size() > 0) && (cyc - qt[0] >= 3);
      chk("rnd_m_valid", m_valid, exp_mv);
      if (exp_mv) chk("rnd_m_data", m_data, q[0]);
      chk("rnd_ram_wr", ram_wr, sv && s_ready);
      if (q.size() < WORDS) chk("rnd_s_ready_room", s_ready, 1);
      if (q.size() == WORDS + 2) chk("rnd_s_ready_full", s_ready, 0);
      if (ram_wr) begin
        chk("rnd_waddr", ram_waddr, npush % WORDS);
        chk("rnd_wdata", ram_wdata, d);
      end
      if (m_valid && mr && q.size() > 0) begin
        void'(q.pop_front());
        void'(qt.pop_front());
      end
      if (sv && s_ready) begin
        q.push_back(d);
        qt.push_back(cyc);
        npush++;
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
